// File: rtl/l1i_bus_if.sv
// L1I refill bus bundle.
//   master: drives arvalid/araddr, receives rready/rdata/rvalid/rlast.
//   slave : receives arvalid/araddr, drives rready/rdata/rvalid/rlast.
// rready doubles as the request-accept signal. There is no read-side
// backpressure: every beat is consumed in the cycle it is valid.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface l1i_bus_if #(
   parameter int XLEN = `YSYX_XLEN
);
   logic            arvalid;
   logic [XLEN-1:0] araddr;
   logic            rready;
   logic [XLEN-1:0] rdata;
   logic            rvalid;
   logic            rlast;

   modport master (output arvalid, araddr, input rready, rdata, rvalid, rlast);
   modport slave  (input arvalid, araddr, output rready, rdata, rvalid, rlast);
endinterface

// File: rtl/ysyx_l1i_bus_resp.sv
// ysyx_l1i_bus_resp: responder end of the L1I refill bus. Accepts a line
// request, waits LATENCY cycles, then streams LINE_WORDS 32-bit words, one
// per cycle, from an internal word-addressed array.
//
// Ports:
//   clock, reset  - clock; synchronous active-low reset
//   bus (slave)   - arvalid/araddr request, rready idle/accept,
//                   rdata/rvalid/rlast beat outputs
//   init_wen/init_addr/init_data - preload write port, works in any state
//
// Optional feature macro: YSYX_L1I_RESP_CWF_EN (critical-word-first).
// When defined, the burst starts at the requested word and wraps within the
// line; otherwise it always starts at the line base.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_l1i_bus_resp #(
   parameter int XLEN       = `YSYX_XLEN,
   parameter int LINE_WORDS = 4,
   parameter int MEM_WORDS  = 4096,
   parameter int LATENCY    = 2
) (
   input  logic            clock,
   input  logic            reset,
   l1i_bus_if.slave        bus,
   input  logic            init_wen,
   input  logic [XLEN-1:0] init_addr,
   input  logic [31:0]     init_data
);
   localparam int AW = $clog2(MEM_WORDS);
   localparam int LW = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t          state_q, state_d;
   logic [3:0]      lat_q, lat_d;
   logic [LW-1:0]   beat_q, beat_d;   // index of the next beat to launch
   logic [AW-1:0]   idx_q, idx_d;     // captured request word index
   logic            launch;
   logic [LW-1:0]   launch_k;
   logic            launch_last;
   logic [LW-1:0]   word_off;
   logic [AW-1:0]   rd_idx;

   logic            rvalid_q, rlast_q;
   logic [XLEN-1:0] rdata_q;

   logic [31:0]     mem [MEM_WORDS];

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      beat_d      = beat_q;
      idx_d       = idx_q;
      launch      = 1'b0;
      launch_k    = beat_q;
      launch_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.arvalid) begin
               idx_d   = bus.araddr[AW+1:2];
               lat_d   = 4'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            // the edge that sees a zero count launches beat 0, so the first
            // beat appears LATENCY cycles after the accept edge
            if (lat_q == 4'd0) begin
               state_d  = BURST;
               launch   = 1'b1;
               launch_k = '0;
               beat_d   = LW'(1);
            end else begin
               lat_d = lat_q - 4'd1;
            end
         end
         BURST: begin
            if (rlast_q) begin
               state_d = IDLE;
               beat_d  = '0;
            end else begin
               launch      = 1'b1;
               launch_last = (beat_q == LW'(LINE_WORDS - 1));
               beat_d      = beat_q + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef YSYX_L1I_RESP_CWF_EN
   // offset within the line wraps naturally at LW bits
   assign word_off = launch_k + idx_q[LW-1:0];
`else
   assign word_off = launch_k;
`endif
   assign rd_idx = {idx_q[AW-1:LW], word_off};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         beat_q   <= '0;
         idx_q    <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         if (launch) begin
            rvalid_q <= 1'b1;
            rlast_q  <= launch_last;
            rdata_q  <= mem[rd_idx];
         end else begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rdata_q  <= '0;
         end
      end
   end

   // Backing array: never reset. A same-edge write and beat read of one
   // word returns the old contents since both are non-blocking.
   always_ff @(posedge clock) begin
      if (init_wen) mem[init_addr[AW+1:2]] <= init_data;
   end

   assign bus.rready = (state_q == IDLE);
   assign bus.rvalid = rvalid_q;
   assign bus.rlast  = rlast_q;
   assign bus.rdata  = rdata_q;

   // address bits outside the word index carry no meaning here
   logic unused_bits;
`ifdef YSYX_L1I_RESP_CWF_EN
   assign unused_bits = ^{bus.araddr[XLEN-1:AW+2], bus.araddr[1:0],
                          init_addr[XLEN-1:AW+2], init_addr[1:0]};
`else
   assign unused_bits = ^{bus.araddr[XLEN-1:AW+2], bus.araddr[1:0],
                          init_addr[XLEN-1:AW+2], init_addr[1:0], idx_q[LW-1:0]};
`endif
endmodule

// File: tb/tb_ysyx_l1i_bus_resp.sv
// Bench for ysyx_l1i_bus_resp: a transaction-level reference model (accept
// edge, beat schedule by edge number, reference memory) predicts every cycle
// of bus output; directed constant checks cover the documented scenarios.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module tb_ysyx_l1i_bus_resp;
   localparam int L  = 2;
   localparam int W  = 4;
   localparam int MW = 4096;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        init_wen = 1'b0;
   logic [31:0] init_addr = '0;
   logic [31:0] init_data = '0;

   l1i_bus_if #(.XLEN(32)) bus ();

   ysyx_l1i_bus_resp #(.XLEN(32), .LINE_WORDS(W), .MEM_WORDS(MW), .LATENCY(L)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .init_wen  (init_wen),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // reference model state
   logic [31:0] ref_mem [MW];
   bit          act = 0;
   int          acc_n = 0;
   int          acc_idx = 0;
   int          n = 0;
   logic [31:0] beats [$];

   function automatic int beat_idx(input int idx, input int k);
      int line;
      line = idx & ~(W - 1);
`ifdef YSYX_L1I_RESP_CWF_EN
      return line + ((idx + k) % W);
`else
      return line + k;
`endif
   endfunction

   task automatic step();
      logic        e_v, e_l, e_r;
      logic [31:0] e_d;
      int          k;
      bit          idle_b;
      idle_b = !act || (n - 1 >= acc_n + L + W);
      e_v = 1'b0; e_l = 1'b0; e_d = '0;
      if (!reset) begin
         act = 0;
      end else begin
         if (act) begin
            k = n - acc_n - L;
            if (k >= 0 && k < W) begin
               e_v = 1'b1;
               e_l = (k == W - 1);
               e_d = ref_mem[beat_idx(acc_idx, k)];
            end
         end
         if (idle_b && bus.arvalid) begin
            act     = 1;
            acc_n   = n;
            acc_idx = int'(bus.araddr[13:2]);
         end
      end
      e_r = !act || (n >= acc_n + L + W);
      if (init_wen) ref_mem[init_addr[13:2]] = init_data;
      @(posedge clock);
      #1;
      n++;
      chk("rready", {31'd0, bus.rready}, {31'd0, e_r});
      chk("rvalid", {31'd0, bus.rvalid}, {31'd0, e_v});
      chk("rlast",  {31'd0, bus.rlast},  {31'd0, e_l});
      chk("rdata",  bus.rdata, e_d);
      if (bus.rvalid) beats.push_back(bus.rdata);
   endtask

   task automatic request(input logic [31:0] a);
      bus.arvalid = 1'b1;
      bus.araddr  = a;
      step();
      bus.arvalid = 1'b0;
   endtask

   int          lasts;
   logic [31:0] saved [$];
   logic [31:0] e0, e1, e2, e3;

   initial begin
      bus.arvalid = 1'b0;
      bus.araddr  = '0;
      for (int i = 0; i < MW; i++) ref_mem[i] = '0;

      // reset then idle
      repeat (3) step();
      reset = 1'b1;
      repeat (20) step();
      chk("idle_beats", beats.size(), 0);

      // preload words 0..63 (0..31 per the documented pattern)
      for (int i = 0; i < 64; i++) begin
         init_wen  = 1'b1;
         init_addr = i * 4;
         init_data = (i < 32) ? 32'h1000_0000 + i : $urandom;
         step();
      end
      init_wen = 1'b0;

`ifdef YSYX_L1I_RESP_CWF_EN
      e0 = 32'h1000_0012; e1 = 32'h1000_0013; e2 = 32'h1000_0010; e3 = 32'h1000_0011;
`else
      e0 = 32'h1000_0010; e1 = 32'h1000_0011; e2 = 32'h1000_0012; e3 = 32'h1000_0013;
`endif

      // basic burst
      beats.delete();
      request(32'h48);
      repeat (L + W + 2) step();
      chk("basic_cnt", beats.size(), W);
      if (beats.size() == W) begin
         chk("basic_b0", beats[0], e0);
         chk("basic_b1", beats[1], e1);
         chk("basic_b2", beats[2], e2);
         chk("basic_b3", beats[3], e3);
      end

      // back-to-back with arvalid held; address changes mid-burst
      beats.delete();
      lasts = 0;
      bus.arvalid = 1'b1;
      bus.araddr  = 32'h0;
      for (int i = 0; i < 3 * (L + W + 1); i++) begin
         if (i == L + 1) bus.araddr = 32'h40;
         step();
         if (bus.rlast) lasts++;
      end
      bus.arvalid = 1'b0;
      repeat (L + W + 1) step();
      chk("b2b_bursts", lasts, 3);
      chk("b2b_cnt", beats.size(), 3 * W);
      if (beats.size() == 3 * W) begin
         chk("b2b_first", beats[0], 32'h1000_0000);
         chk("b2b_second", beats[W], 32'h1000_0010);
      end

      // reset mid-burst (during beat 1), then a clean burst
      request(32'h48);
      repeat (L + 1) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mrst_rvalid", {31'd0, bus.rvalid}, 32'd0);
      chk("mrst_rready", {31'd0, bus.rready}, 32'd1);
      beats.delete();
      request(32'h48);
      repeat (L + W + 1) step();
      chk("mrst_cnt", beats.size(), W);
      if (beats.size() == W) begin
         chk("mrst_b0", beats[0], e0);
         chk("mrst_b3", beats[3], e3);
      end

      // read-first: write word 0x11 on the edge that launches beat 1 of 0x40
      request(32'h40);
      repeat (L) step();
      init_wen  = 1'b1;
      init_addr = 32'h44;
      init_data = 32'hDEAD_BEEF;
      step();
      init_wen = 1'b0;
      chk("rf_old", bus.rdata, 32'h1000_0011);
      repeat (W + 1) step();
      beats.delete();
      request(32'h40);
      repeat (L + W + 1) step();
      chk("rf_cnt", beats.size(), W);
      if (beats.size() == W) chk("rf_new", beats[1], 32'hDEAD_BEEF);

      // index wrap: MW*4 + 0x40 aliases 0x40
      saved = beats;
      beats.delete();
      request(MW * 4 + 32'h40);
      repeat (L + W + 1) step();
      chk("wrap_cnt", beats.size(), W);
      if (beats.size() == W && saved.size() == W)
         for (int i = 0; i < W; i++) chk("wrap_beat", beats[i], saved[i]);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 49) != 0);
         bus.arvalid = $urandom_range(0, 1);
         bus.araddr  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 63)) << 2);
         init_wen    = ($urandom_range(0, 9) == 0);
         init_addr   = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 63)) << 2);
         init_data   = $urandom;
         step();
      end
      reset = 1'b1;
      bus.arvalid = 1'b0;
      init_wen = 1'b0;
      repeat (L + W + 2) step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ysyx_l1i_bus_resp.md
Name: ysyx_l1i_bus_resp

Overview:
- Responder (slave) end of the L1I refill bus. Accepts line-fill requests from the L1I master and answers with a fixed-length burst of 32-bit words, one word per cycle.
- Backed by an internal word-addressed memory array with a preload write port.
- Sits below the L1I. Used as the instruction backing store in simulation and standalone builds, and as the reference responder for L1I bus verification.

Parameters:
- XLEN, 32, data/address width; must equal `YSYX_XLEN.
- LINE_WORDS, 4, beats per burst; power of two, >= 2.
- MEM_WORDS, 4096, depth of the backing array in 32-bit words; power of two.
- LATENCY, 2, cycles from the accept cycle to the first beat; range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- arvalid  in  1  master request valid.
- araddr  in  XLEN  request byte address.
- rready  out  1  responder idle and able to accept a request.
- rdata  out  XLEN  beat data.
- rvalid  out  1  beat valid.
- rlast  out  1  final beat of the burst.
- init_wen  in  1  preload write enable.
- init_addr  in  XLEN  preload byte address; bits [1:0] are ignored.
- init_data  in  32  preload data.

Behaviour:
- Interface: the bus-side ports form the slave modport of l1i_bus_if. rready doubles as the request-accept signal. The master has no backpressure: every beat is consumed in the cycle it is valid.
- Reset (reset==0 at an edge):
  - state := IDLE.
  - rready=1, rvalid=0, rlast=0, rdata=0.
  - Beat and latency counters := 0.
  - Memory contents are not cleared.
  - Reset asserted mid-burst aborts the burst immediately; no further beats.
- States: IDLE, WAIT, BURST.
- IDLE:
  - rready=1.
  - On arvalid && rready at an edge: capture araddr, move to WAIT, load the latency counter with LATENCY-1, drop rready next cycle.
  - arvalid is ignored whenever rready=0; no queueing.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, move to BURST with the first beat registered.
  - Result: rvalid is first high exactly LATENCY cycles after the accept cycle (LATENCY=1 gives a beat in the cycle right after accept).
- BURST:
  - One beat per cycle for LINE_WORDS consecutive cycles; rvalid stays continuously high.
  - rlast=1 only on beat LINE_WORDS-1.
  - The cycle after rlast: state returns to IDLE, rvalid=0, rready=1.
  - A new request can be accepted in that same cycle; minimum request spacing is LATENCY+LINE_WORDS+1 cycles.
- Addressing:
  - Word index = byte_addr[log2(MEM_WORDS)+1:2], which wraps modulo MEM_WORDS.
  - Line base = captured word index with its low log2(LINE_WORDS) bits cleared.
  - Beat k reads word (base + k).
- Data:
  - rdata is registered, read from the array at the edge that launches the beat.
  - Outside beats, rdata=0 and rlast=0.
- Preload:
  - init_wen writes mem[init_addr word index] := init_data at the edge; it works in any state.
  - Same-edge write and beat read of the same word returns the OLD data (read-first).
- Capture: araddr is sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: YSYX_L1I_RESP_CWF_EN (critical-word-first).
- Defined: beat k reads line word ((crit + k) mod LINE_WORDS), where crit = captured word index low log2(LINE_WORDS) bits. The burst wraps within the line; rlast stays on the LINE_WORDS-th beat.
- Undefined: bursts always start at the line base, and the low araddr bits below the line are ignored.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release -> rready=1, rvalid=0, rlast=0, rdata=0 every cycle; no spurious beats over 20 idle cycles.
- Basic burst: preload mem[i]=0x10000000+i for i=0..31; LATENCY=2; arvalid with araddr=0x48 for one cycle -> rvalid high in cycles T+2..T+5 with rdata 0x10000010, 0x10000011, 0x10000012, 0x10000013, rlast only at T+5. With CWF_EN: 0x10000012, 0x10000013, 0x10000010, 0x10000011.
- Busy ignore and back-to-back: hold arvalid=1 continuously with araddr=0x0 -> exactly one burst per LATENCY+LINE_WORDS+1 cycles; rready=0 throughout WAIT and BURST; araddr changed to 0x40 mid-burst affects only the next burst.
- Reset mid-burst: assert reset=0 during beat 1 -> the next cycle has rvalid=0, rready=1; a following request to 0x48 returns the full correct 4-beat burst.
- Read-first and wrap: init_wen writes 0xDEADBEEF to word 0x11 on the same edge as beat 1 of a burst at 0x40 -> beat 1 returns 0x10000011, and a later burst returns 0xDEADBEEF. A request at araddr=MEM_WORDS*4+0x40 returns the same data as 0x40.
